// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: word-organised RAM with little-endian byte lanes,
// programmable data-phase wait states and a two-cycle ERROR response.
module ahb_lite_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LOC_W = IDX_W + 2;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_r;
    state_t                state_next_s;
    logic                  hreadyout_r;
    logic                  hresp_r;
    logic                  ready_next_s;
    logic                  resp_next_s;
    logic [LOC_W-1:0]      addr_r;
    logic                  write_r;
    logic [2:0]            size_r;
    logic                  pend_r;
    logic [3:0]            count_r;
    logic [DATA_WIDTH-1:0] hrdata_r;

    logic                  trans_active_s;
    logic                  accept_s;
    logic                  err_s;
    logic                  done_s;
    logic                  wr_commit_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic                  rd_load_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
        logic [3:0] mask;
        case (size)
            3'd0:    mask = 4'b0001 << lsb;
            3'd1:    mask = lsb[1] ? 4'b1100 : 4'b0011;
            3'd2:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_word,
                                                          input logic [DATA_WIDTH-1:0] wdata,
                                                          input logic [3:0]            mask);
        logic [DATA_WIDTH-1:0] word;
        word = old_word;
        for (int i = 0; i < 4; i++) begin
            word[8*i +: 8] = mask[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
        end
        return word;
    endfunction

    function automatic logic xfer_error(input logic [2:0] size, input logic [ADDR_WIDTH-1:0] addr);
        return (size > 3'd2) ||
               ((size == 3'd1) && addr[0]) ||
               ((size == 3'd2) && (addr[1:0] != 2'b00)) ||
               ({1'b0, addr} >= MEM_BYTES);
    endfunction

    assign trans_active_s = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    // Address phases are only taken while this slave itself is ready.
    assign accept_s       = HSEL && HREADY && trans_active_s && hreadyout_r;
    assign err_s          = xfer_error(HSIZE, HADDR);
    assign done_s         = (state_r == ST_IDLE) && pend_r;
    assign wr_commit_s    = done_s && write_r;
    assign wr_idx_s       = addr_r[LOC_W-1:2];
    assign wr_data_s      = merge_lanes(mem[wr_idx_s], HWDATA, lane_mask(size_r, addr_r[1:0]));

    // FSM state and registered bus responses
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            hreadyout_r <= ready_next_s;
            hresp_r     <= resp_next_s;
        end
    end

    // FSM next-state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_next_s = ST_ERR1;
                    end else if (WAIT_INIT == 4'd0) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (count_r <= 4'd1) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ERR1: state_next_s = ST_ERR2;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the state being entered so they can be registered
    always_comb begin
        ready_next_s = 1'b1;
        resp_next_s  = 1'b0;
        case (state_next_s)
            ST_IDLE: begin ready_next_s = 1'b1; resp_next_s = 1'b0; end
            ST_WAIT: begin ready_next_s = 1'b0; resp_next_s = 1'b0; end
            ST_ERR1: begin ready_next_s = 1'b0; resp_next_s = 1'b1; end
            ST_ERR2: begin ready_next_s = 1'b1; resp_next_s = 1'b1; end
            default: begin ready_next_s = 1'b1; resp_next_s = 1'b0; end
        endcase
    end

    // Captured address phase, pending-transfer flag and wait counter
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_r  <= '0;
            write_r <= 1'b0;
            size_r  <= 3'd0;
            pend_r  <= 1'b0;
            count_r <= 4'd0;
        end else if (accept_s) begin
            addr_r  <= HADDR[LOC_W-1:0];
            write_r <= HWRITE;
            size_r  <= HSIZE;
            pend_r  <= !err_s;
            count_r <= err_s ? 4'd0 : WAIT_INIT;
        end else begin
            pend_r  <= done_s ? 1'b0 : pend_r;
            count_r <= ((state_r == ST_WAIT) && (count_r != 4'd0)) ? count_r - 4'd1 : count_r;
        end
    end

    // Read data is loaded on the edge that opens the read's completing cycle
    always_comb begin
        rd_load_s = 1'b0;
        rd_idx_s  = addr_r[LOC_W-1:2];
        if (accept_s && !err_s && !HWRITE && (WAIT_INIT == 4'd0)) begin
            rd_load_s = 1'b1;
            rd_idx_s  = HADDR[LOC_W-1:2];
        end else if ((state_r == ST_WAIT) && (count_r <= 4'd1) && !write_r) begin
            rd_load_s = 1'b1;
            rd_idx_s  = addr_r[LOC_W-1:2];
        end else begin
            rd_load_s = 1'b0;
            rd_idx_s  = addr_r[LOC_W-1:2];
        end
    end

    // A write committing on the same edge is forwarded into the read word
    assign rd_word_s = (wr_commit_s && (wr_idx_s == rd_idx_s)) ? wr_data_s : mem[rd_idx_s];

    // Read data register, zero outside a read's completing cycle
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hrdata_r <= '0;
        end else begin
            hrdata_r <= rd_load_s ? rd_word_s : '0;
        end
    end

    // Memory array, deliberately outside the reset domain
    always_ff @(posedge HCLK) begin
        if (wr_commit_s) begin
            mem[wr_idx_s] <= wr_data_s;
        end
    end

    assign HRDATA    = hrdata_r;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: two instances (one and zero wait states) on a
// shared bus, directed scenarios plus random transfers against a word-array model.
module tb_ahb_lite_mem_slave;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    int          dsel;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        bus_ready;
    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1, rsp0, rsp1;

    int n_checks;
    int n_fail;

    logic [31:0] mdl [2][DEPTH];

    always #5 clk = ~clk;

    assign bus_ready = (dsel == 0) ? rdy0 : rdy1;

    ahb_lite_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && (dsel == 0)), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HREADY(bus_ready), .HWDATA(hwdata),
        .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(rsp0));

    ahb_lite_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && (dsel == 1)), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HREADY(bus_ready), .HWDATA(hwdata),
        .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(rsp1));

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic bit is_err(input logic [2:0] sz, input logic [31:0] a);
        return (sz > 3'd2) || (sz == 3'd1 && (a % 2) != 0) || (sz == 3'd2 && (a % 4) != 0) ||
               (a >= 32'(4 * DEPTH));
    endfunction

    // Little-endian: the access covers bytes (a mod 4) .. (a mod 4)+size-1 of word a/4.
    task automatic model_write(input int d, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int first;
        int nbytes;
        first  = int'(a % 4);
        nbytes = 1 << sz;
        for (int k = first; k < first + nbytes; k++) begin
            mdl[d][a / 4][8*k +: 8] = wd[8*k +: 8];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: sample at the falling edge, return just after the next rising edge.
    task automatic cyc(input int d, input string tag, input logic er, input logic ep, input logic [31:0] ed);
        @(negedge clk);
        check({tag, ".hreadyout"}, 32'(d == 0 ? rdy0 : rdy1), 32'(er));
        check({tag, ".hresp"},     32'(d == 0 ? rsp0 : rsp1), 32'(ep));
        check({tag, ".hrdata"},    (d == 0) ? rdata0 : rdata1, ed);
        @(posedge clk); #1;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
        bit          err;
        logic [31:0] exp_rd;
        err  = is_err(sz, a);
        dsel = d; hsel = 1'b1; haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10; hwdata = 32'h0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; haddr = $urandom; hwdata = wd;
        if (err) begin
            cyc(d, {tag, ".err1"}, 1'b0, 1'b1, 32'h0);
            cyc(d, {tag, ".err2"}, 1'b1, 1'b1, 32'h0);
        end else begin
            for (int i = 0; i < wait_of(d); i++) cyc(d, {tag, ".wait"}, 1'b0, 1'b0, 32'h0);
            exp_rd = wr ? 32'h0 : mdl[d][a / 4];
            cyc(d, {tag, ".done"}, 1'b1, 1'b0, exp_rd);
            if (wr) model_write(d, sz, a, wd);
        end
    endtask

    // Word write immediately followed by a read of the same address, no idle cycle between.
    task automatic pipe(input int d, input logic [31:0] a, input logic [31:0] wd, input string tag);
        dsel = d; hsel = 1'b1; haddr = a; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk); #1;
        hwdata = wd; hwrite = 1'b0;
        for (int i = 0; i < wait_of(d); i++) cyc(d, {tag, ".wwait"}, 1'b0, 1'b0, 32'h0);
        cyc(d, {tag, ".wdone"}, 1'b1, 1'b0, 32'h0);
        model_write(d, 3'd2, a, wd);
        hsel = 1'b0; htrans = 2'b00; hwdata = $urandom;
        for (int i = 0; i < wait_of(d); i++) cyc(d, {tag, ".rwait"}, 1'b0, 1'b0, 32'h0);
        cyc(d, {tag, ".rdone"}, 1'b1, 1'b0, mdl[d][a / 4]);
    endtask

    task automatic idle_probe(input int d, input logic sel, input logic [1:0] tr, input string tag);
        dsel = d; hsel = sel; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = tr;
        hwdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        cyc(d, tag, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        int          kind;
        int          d;
        logic [2:0]  sz;
        logic [31:0] a;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; dsel = 0; hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
        htrans = 2'b00; hwdata = 32'h0;

        #2;
        check("reset.ws1.hreadyout", 32'(rdy0), 32'h1);
        check("reset.ws1.hresp",     32'(rsp0), 32'h0);
        check("reset.ws1.hrdata",    rdata0,    32'h0);
        check("reset.ws0.hreadyout", 32'(rdy1), 32'h1);
        check("reset.ws0.hresp",     32'(rsp1), 32'h0);
        check("reset.ws0.hrdata",    rdata1,    32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int dd = 0; dd < 2; dd++) begin
            for (int w = 0; w < 32; w++) xfer(dd, 1'b1, 3'd2, 32'(w * 4), $urandom, "init");
        end

        xfer(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, "r19.wr");
        xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, "r19.rd");

        xfer(0, 1'b1, 3'd2, 32'h20, 32'h0000_0000, "r20.word");
        xfer(0, 1'b1, 3'd0, 32'h22, 32'h00AA_0000, "r20.byte");
        xfer(0, 1'b1, 3'd1, 32'h20, 32'h0000_1234, "r20.half");
        xfer(0, 1'b0, 3'd2, 32'h20, 32'h0, "r20.rd");
        xfer(1, 1'b1, 3'd1, 32'h46, 32'hBEEF_0000, "half.hi");
        xfer(1, 1'b0, 3'd2, 32'h44, 32'h0, "half.rd");

        xfer(0, 1'b0, 3'd2, 32'h06, 32'h0, "r21.unaligned");
        xfer(0, 1'b1, 3'd2, 32'(4 * DEPTH), 32'h1357_9BDF, "r21.range");
        xfer(0, 1'b0, 3'd2, 32'h0, 32'h0, "r21.word0");
        xfer(1, 1'b1, 3'd1, 32'h51, 32'hFFFF_FFFF, "err.half_odd");
        xfer(1, 1'b1, 3'd3, 32'h50, 32'hFFFF_FFFF, "err.size3");
        xfer(1, 1'b0, 3'd2, 32'h50, 32'h0, "err.rdback");

        pipe(1, 32'h30, 32'h0000_0055, "r22");
        pipe(0, 32'h34, $urandom, "pipe.ws1");

        idle_probe(0, 1'b1, 2'b00, "r23.idle");
        idle_probe(0, 1'b0, 2'b10, "r23.unsel");
        idle_probe(1, 1'b1, 2'b01, "r23.busy");
        xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, "r23.rd0");
        xfer(1, 1'b0, 3'd2, 32'h10, 32'h0, "r23.rd1");

        dsel = 0; hsel = 1'b1; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
        #2;
        check("r24.inwait", 32'(rdy0), 32'h0);
        rst = 1'b1;
        #1;
        check("r24.hreadyout", 32'(rdy0), 32'h1);
        check("r24.hresp",     32'(rsp0), 32'h0);
        check("r24.hrdata",    rdata0,    32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        xfer(0, 1'b0, 3'd2, 32'h40, 32'h0, "r24.rd");
        xfer(1, 1'b0, 3'd2, 32'h30, 32'h0, "r24.kept");

        for (int it = 0; it < 80; it++) begin
            d    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                pipe(d, 32'($urandom_range(0, 31) * 4), $urandom, "rnd.pipe");
            end else begin
                sz = (kind == 9) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
                a  = (kind == 8) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 32'h00FF_FFFF))
                                 : 32'($urandom_range(0, 127));
                xfer(d, 1'($urandom_range(0, 1)), sz, a, $urandom, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
